// File: rtl/kbd_coord_pkg.sv
// rtl/kbd_coord_pkg.sv - shared constants and types for the keyboard coordinate entry block
// Contents: PS/2 set-2 scancode constants, entry FSM state encoding, timeout timer width.
package kbd_coord_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Digit make codes, 0..9
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  // Letter make codes, A..J
  localparam logic [7:0] SC_LA = 8'h1C;
  localparam logic [7:0] SC_LB = 8'h32;
  localparam logic [7:0] SC_LC = 8'h21;
  localparam logic [7:0] SC_LD = 8'h23;
  localparam logic [7:0] SC_LE = 8'h24;
  localparam logic [7:0] SC_LF = 8'h2B;
  localparam logic [7:0] SC_LG = 8'h34;
  localparam logic [7:0] SC_LH = 8'h33;
  localparam logic [7:0] SC_LI = 8'h43;
  localparam logic [7:0] SC_LJ = 8'h3B;

  localparam int TIMER_W = 28;

  typedef enum logic [1:0] {
    ST_WAIT_X = 2'b00,
    ST_WAIT_Y = 2'b01,
    ST_READY  = 2'b10
  } entry_state_t;

endpackage

// File: rtl/kbd_coord_entry_decoder.sv
// rtl/kbd_coord_entry_decoder.sv - combinational make-code classifier (module scancode_digit_decoder)
// Ports: i_code   scancode byte
//        o_is_digit/o_value  digit key and its value 0..9
//        o_is_letter         letter A..J (value in o_value); only when KBD_LETTER_COL_EN is defined
//        o_is_enter/o_is_bksp/o_is_esc  control keys
// Macro: KBD_LETTER_COL_EN enables letter decode.
module scancode_digit_decoder
  import kbd_coord_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_is_digit,
  output logic       o_is_letter,
  output logic [3:0] o_value,
  output logic       o_is_enter,
  output logic       o_is_bksp,
  output logic       o_is_esc
);

  always_comb begin
    o_is_digit  = 1'b1;
    o_is_letter = 1'b0;
    o_value     = 4'd0;
    case (i_code)
      SC_D0: o_value = 4'd0;
      SC_D1: o_value = 4'd1;
      SC_D2: o_value = 4'd2;
      SC_D3: o_value = 4'd3;
      SC_D4: o_value = 4'd4;
      SC_D5: o_value = 4'd5;
      SC_D6: o_value = 4'd6;
      SC_D7: o_value = 4'd7;
      SC_D8: o_value = 4'd8;
      SC_D9: o_value = 4'd9;
      default: o_is_digit = 1'b0;
    endcase
`ifdef KBD_LETTER_COL_EN
    if (!o_is_digit) begin
      o_is_letter = 1'b1;
      case (i_code)
        SC_LA: o_value = 4'd0;
        SC_LB: o_value = 4'd1;
        SC_LC: o_value = 4'd2;
        SC_LD: o_value = 4'd3;
        SC_LE: o_value = 4'd4;
        SC_LF: o_value = 4'd5;
        SC_LG: o_value = 4'd6;
        SC_LH: o_value = 4'd7;
        SC_LI: o_value = 4'd8;
        SC_LJ: o_value = 4'd9;
        default: o_is_letter = 1'b0;
      endcase
    end
`endif
  end

  assign o_is_enter = (i_code == SC_ENTER);
  assign o_is_bksp  = (i_code == SC_BKSP);
  assign o_is_esc   = (i_code == SC_ESC);

endmodule

// File: rtl/kbd_coord_entry.sv
// rtl/kbd_coord_entry.sv - PS/2 scancode stream to validated {X,Y} board coordinate
// Ports: clock, resetn (async active-low)
//        scan_code/scan_valid   keyboard receiver byte + strobe
//        coord                  live entry {X,Y}
//        coord_ready            both coordinates entered, not committed
//        commit/commit_coord    one-cycle commit pulse and captured coordinate
//        entry_state            FSM state for LEDs
//        err                    one-cycle pulse on rejected key or timeout
// Macro: KBD_LETTER_COL_EN (letters A..J accepted as X column, via the decoder).
module kbd_coord_entry
  import kbd_coord_pkg::*;
#(
  parameter int unsigned COORD_MAX      = 9,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] coord,
  output logic       coord_ready,
  output logic       commit,
  output logic [7:0] commit_coord,
  output logic [1:0] entry_state,
  output logic       err
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  entry_state_t       r_state, w_state_nxt;
  logic [3:0]         r_x, r_y, w_x_nxt, w_y_nxt;
  logic               r_brk, r_ext, w_brk_nxt, w_ext_nxt;
  logic               r_commit, r_err, w_commit_nxt, w_err_nxt;
  logic [7:0]         r_commit_coord, w_commit_coord_nxt;
  logic [TIMER_W-1:0] r_timer, w_timer_nxt;

  logic       w_dec_digit, w_dec_letter, w_dec_enter, w_dec_bksp, w_dec_esc;
  logic [3:0] w_dec_value;
  logic       w_key, w_enter, w_expired, w_in_range;

  scancode_digit_decoder u_dec (
    .i_code      (scan_code),
    .o_is_digit  (w_dec_digit),
    .o_is_letter (w_dec_letter),
    .o_value     (w_dec_value),
    .o_is_enter  (w_dec_enter),
    .o_is_bksp   (w_dec_bksp),
    .o_is_esc    (w_dec_esc)
  );

  assign w_in_range = (32'(w_dec_value) <= COORD_MAX);
  assign w_expired  = (TIMEOUT_CYCLES != 0) && (r_state != ST_WAIT_X) && (r_timer == TIMER_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_WAIT_X;
      r_x            <= 4'd0;
      r_y            <= 4'd0;
      r_brk          <= 1'b0;
      r_ext          <= 1'b0;
      r_commit       <= 1'b0;
      r_err          <= 1'b0;
      r_commit_coord <= 8'h00;
      r_timer        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_x            <= w_x_nxt;
      r_y            <= w_y_nxt;
      r_brk          <= w_brk_nxt;
      r_ext          <= w_ext_nxt;
      r_commit       <= w_commit_nxt;
      r_err          <= w_err_nxt;
      r_commit_coord <= w_commit_coord_nxt;
      r_timer        <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_x_nxt            = r_x;
    w_y_nxt            = r_y;
    w_brk_nxt          = r_brk;
    w_ext_nxt          = r_ext;
    w_commit_nxt       = 1'b0;
    w_err_nxt          = 1'b0;
    w_commit_coord_nxt = r_commit_coord;
    w_key              = 1'b0;
    w_enter            = 1'b0;

    // Timer only advances while a partial/complete entry is pending.
    if (TIMEOUT_CYCLES == 0 || r_state == ST_WAIT_X) w_timer_nxt = '0;
    else                                             w_timer_nxt = r_timer + TIMER_W'(1);

    if (scan_valid) begin
      w_timer_nxt = '0;
      if (scan_code == SC_BREAK) begin
        w_brk_nxt = 1'b1;
      end else if (scan_code == SC_EXT) begin
        w_ext_nxt = 1'b1;
      end else if (r_brk) begin
        // Released key (plain or extended): swallow it and drop both prefixes.
        w_brk_nxt = 1'b0;
        w_ext_nxt = 1'b0;
      end else if (r_ext) begin
        // Only keypad Enter matters in the extended table; the rest vanish silently.
        w_ext_nxt = 1'b0;
        w_enter   = (scan_code == SC_ENTER);
        w_key     = w_enter;
      end else begin
        w_key   = 1'b1;
        w_enter = w_dec_enter;
      end
    end

    if (w_key) begin
      if (w_dec_esc && !r_ext) begin
        w_x_nxt     = 4'd0;
        w_y_nxt     = 4'd0;
        w_state_nxt = ST_WAIT_X;
      end else if (w_enter) begin
        if (r_state == ST_READY) begin
          w_commit_nxt       = 1'b1;
          w_commit_coord_nxt = {r_x, r_y};
          w_state_nxt        = ST_WAIT_X;
        end else begin
          w_err_nxt = 1'b1;
        end
      end else if (w_dec_bksp) begin
        if (r_state == ST_READY) begin
          w_y_nxt     = 4'd0;
          w_state_nxt = ST_WAIT_Y;
        end else if (r_state == ST_WAIT_Y) begin
          w_x_nxt     = 4'd0;
          w_state_nxt = ST_WAIT_X;
        end
      end else if (w_dec_digit || (w_dec_letter && r_state == ST_WAIT_X)) begin
        if (!w_in_range || r_state == ST_READY) begin
          w_err_nxt = 1'b1;
        end else if (r_state == ST_WAIT_X) begin
          w_x_nxt     = w_dec_value;
          w_y_nxt     = 4'd0;
          w_state_nxt = ST_WAIT_Y;
        end else begin
          w_y_nxt     = w_dec_value;
          w_state_nxt = ST_READY;
        end
      end else begin
        w_err_nxt = 1'b1;
      end
    end else if (!scan_valid && w_expired) begin
      w_x_nxt     = 4'd0;
      w_y_nxt     = 4'd0;
      w_state_nxt = ST_WAIT_X;
      w_err_nxt   = 1'b1;
      w_timer_nxt = '0;
    end
  end

  assign coord        = {r_x, r_y};
  assign coord_ready  = (r_state == ST_READY);
  assign commit       = r_commit;
  assign commit_coord = r_commit_coord;
  assign entry_state  = r_state;
  assign err          = r_err;

endmodule
